wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs (rd_waddr, rd_wena, rd_sel, alu_result, dmem_data) and selects the write-back value.
- Commits that value into a 32x32 register file on the clock edge and serves the two ID-stage read ports.
- Keeps a committed-write counter for CPI/debug instrumentation.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5).
- DW, 32, data width of registers and write-back path.
- CNT_W, 32, width of the retirement counter.

Ports:
- clk_i  in  1  pipeline clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- rd_waddr_i  in  5  destination register from MEM/WB
- rd_wena_i  in  1  write enable from MEM/WB
- rd_sel_i  in  1  write-back source select: 1 = dmem_data_i, 0 = alu_result_i
- alu_result_i  in  DW  ALU result from MEM/WB
- dmem_data_i  in  DW  load data from MEM/WB
- rs1_addr_i  in  5  ID-stage read address A
- rs2_addr_i  in  5  ID-stage read address B
- rs1_data_o  out  DW  read data A
- rs2_data_o  out  DW  read data B
- wb_data_o  out  DW  selected write-back value (combinational, for EX forwarding)
- wb_commit_o  out  1  high when the current cycle's write actually commits
- retire_cnt_o  out  CNT_W  count of committed register writes

Behaviour:
- Reset: when rst_i=1 at a rising edge, all NREG registers clear to 0 and retire_cnt_o clears to 0. The reset overrides any write in the same cycle.
- Write-back select: wb_data_o = rd_sel_i ? dmem_data_i : alu_result_i. This output is combinational and valid every cycle regardless of rd_wena_i.
- Commit condition: wb_commit_o = rd_wena_i && (rd_waddr_i != 0) && !rst_i. This output is combinational.
- Write: on a rising edge with wb_commit_o=1, regs[rd_waddr_i] <= wb_data_o. Write latency is one cycle to architectural state.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded and do not count.
  - Reads of address 0 always return 0, including under bypass.
- Read ports are combinational (asynchronous read) of the register array. Read-during-write handling is given under Optional Feature.
- Both ports may read the same address, including the address being written; both return identical data.
- retire_cnt_o increments by 1 on each edge where wb_commit_o=1. It wraps modulo 2^CNT_W, so all-ones rolls to 0.
- Reset mid-operation: a pending MEM/WB write in the reset cycle is lost, and the counter returns to 0. Normal operation resumes the cycle after rst_i deasserts.
- Unknown or X inputs with rd_wena_i=0 must not alter state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first internal bypass. If wb_commit_o=1 and rsN_addr_i == rd_waddr_i, then rsN_data_o = wb_data_o in the same cycle. This gives a same-cycle WB->ID hand-off, and the hazard unit needs no WB forwarding case.
- Undefined: read-first. rsN_data_o returns the old array contents until the edge after the write. The pipeline must then rely on a negedge-write or stall policy elsewhere.
- The address-0 rule holds in both builds.

Test Plan:
- Reset then read: assert rst_i for 2 cycles, read rs1=5, rs2=31 -> both outputs 0x00000000, retire_cnt_o=0.
- ALU write-back: rd_waddr=3, wena=1, sel=0, alu=0x1234ABCD, dmem=0xFFFFFFFF for one cycle, then read rs1=3 -> 0x1234ABCD; wb_data_o was 0x1234ABCD during the write cycle; retire_cnt_o=1.
- Load write-back and x0: write waddr=7 with sel=1, dmem=0xDEADBEEF, then write waddr=0 with alu=0x55 -> rs1=7 returns 0xDEADBEEF, rs2=0 returns 0, retire_cnt_o advanced only by 1.
- Read-during-write: regs[9]=0x11; in one cycle write waddr=9 with alu=0x22 while rs1=rs2=9 -> with REGFILE_BYPASS_EN both read 0x22 in that cycle; without it both read 0x11; both read 0x22 on the next cycle.
- Disabled write and reset override: wena=0, waddr=4, alu=0x99 -> regs[4] unchanged, counter unchanged. Then rst_i=1 together with wena=1, waddr=4, alu=0x77 -> regs[4]=0, counter=0.
- Counter wrap: build with CNT_W=4 and perform 17 committed writes -> retire_cnt_o reads 15 after the 15th write, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back select, 32x32 register file with two async read ports,
// and a committed-write counter for CPI/debug instrumentation.
//
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   rd_waddr_i         destination register from MEM/WB
//   rd_wena_i          write enable from MEM/WB
//   rd_sel_i           1 = dmem_data_i, 0 = alu_result_i
//   alu_result_i       ALU result from MEM/WB
//   dmem_data_i        load data from MEM/WB
//   rs1_addr_i         ID read address A
//   rs2_addr_i         ID read address B
//   rs1_data_o         read data A
//   rs2_data_o         read data B
//   wb_data_o          selected write-back value (combinational)
//   wb_commit_o        current cycle's write commits (combinational)
//   retire_cnt_o       count of committed writes, wraps
//
// Build option: define REGFILE_BYPASS_EN for write-first reads
// (same-cycle WB->ID hand-off). Default build is read-first.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rd_waddr_i,
  input  logic             rd_wena_i,
  input  logic             rd_sel_i,
  input  logic [DW-1:0]    alu_result_i,
  input  logic [DW-1:0]    dmem_data_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  output logic [DW-1:0]    rs1_data_o,
  output logic [DW-1:0]    rs2_data_o,
  output logic [DW-1:0]    wb_data_o,
  output logic             wb_commit_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic [DW-1:0]    regs [NREG];
  logic [CNT_W-1:0] cnt_q;

  assign wb_data_o = rd_sel_i ? dmem_data_i : alu_result_i;

  // Writes to x0 never commit, so x0 also never counts.
  assign wb_commit_o = rd_wena_i
                    && (rd_waddr_i != 5'd0)
                    && !rst_i;

  assign retire_cnt_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      cnt_q <= '0;
    end else if (wb_commit_o) begin
      regs[rd_waddr_i] <= wb_data_o;
      cnt_q            <= cnt_q + CNT_W'(1);
    end
  end

  // x0 reads as zero even when a bypass would match it.
  function automatic logic [DW-1:0] rd_port(
    input logic [4:0] addr
  );
    logic [DW-1:0] d;
    d = '0;
    if (addr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_commit_o && (addr == rd_waddr_i)) begin
        d = wb_data_o;
      end else begin
        d = regs[addr];
      end
`else
      d = regs[addr];
`endif
    end
    return d;
  endfunction

  always_comb begin
    rs1_data_o = rd_port(rs1_addr_i);
    rs2_data_o = rd_port(rs2_addr_i);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for the wrap check.
module tb_wb_regfile;

  localparam int P_RS1 = 0;
  localparam int P_RS2 = 1;
  localparam int P_WB  = 2;
  localparam int P_CMT = 3;
  localparam int P_CNT = 4;
  localparam int P_SCN = 5;
  localparam int P_SR1 = 6;
  localparam int P_SCM = 7;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [4:0]  waddr;
  logic        wena;
  logic        sel;
  logic [31:0] alu;
  logic [31:0] dmem;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] wb;
  logic        cmt;
  logic [31:0] cnt;
  logic [31:0] s_rs1;
  logic [31:0] s_rs2;
  logic [31:0] s_wb;
  logic        s_cmt;
  logic [3:0]  s_cnt;

  sb_t q[$];
  int  n_cmp;
  int  n_bad;
  logic [31:0] rdw_exp;

  wb_regfile dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_waddr_i   (waddr),
    .rd_wena_i    (wena),
    .rd_sel_i     (sel),
    .alu_result_i (alu),
    .dmem_data_i  (dmem),
    .rs1_addr_i   (ra),
    .rs2_addr_i   (rb),
    .rs1_data_o   (rs1),
    .rs2_data_o   (rs2),
    .wb_data_o    (wb),
    .wb_commit_o  (cmt),
    .retire_cnt_o (cnt)
  );

  wb_regfile #(.CNT_W(4)) dut_s (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_waddr_i   (waddr),
    .rd_wena_i    (wena),
    .rd_sel_i     (sel),
    .alu_result_i (alu),
    .dmem_data_i  (dmem),
    .rs1_addr_i   (ra),
    .rs2_addr_i   (rb),
    .rs1_data_o   (s_rs1),
    .rs2_data_o   (s_rs2),
    .wb_data_o    (s_wb),
    .wb_commit_o  (s_cmt),
    .retire_cnt_o (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic push(
    input string       tag,
    input int          port,
    input logic [31:0] exp
  );
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic cyc(
    input logic        r,
    input logic        we,
    input logic [4:0]  wa,
    input logic        sl,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [4:0]  x,
    input logic [4:0]  y
  );
    @(posedge clk);
    #1;
    rst   = r;
    wena  = we;
    waddr = wa;
    sel   = sl;
    alu   = a;
    dmem  = d;
    ra    = x;
    rb    = y;
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.port)
        P_RS1:   obs = rs1;
        P_RS2:   obs = rs2;
        P_WB:    obs = wb;
        P_CMT:   obs = {31'd0, cmt};
        P_CNT:   obs = cnt;
        P_SCN:   obs = {28'd0, s_cnt};
        P_SR1:   obs = s_rs1;
        default: obs = {31'd0, s_cmt};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; wena = 1'b0; waddr = '0; sel = 1'b0;
    alu = '0; dmem = '0; ra = '0; rb = '0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 31);
    push("rst_rs1", P_RS1, 32'h0);
    push("rst_rs2", P_RS2, 32'h0);
    push("rst_cnt", P_CNT, 32'h0);
    push("rst_cmt", P_CMT, 32'h0);
    drain();

    cyc(0, 1, 3, 0, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0);
    push("alu_wb", P_WB, 32'h1234ABCD);
    push("alu_cmt", P_CMT, 32'h1);
    drain();
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    push("alu_rd", P_RS1, 32'h1234ABCD);
    push("alu_cnt", P_CNT, 32'h1);
    drain();

    cyc(0, 1, 7, 1, 32'h0000_0011, 32'hDEADBEEF, 0, 0);
    push("ld_wb", P_WB, 32'hDEADBEEF);
    drain();
    cyc(0, 1, 0, 0, 32'h55, 32'h0, 7, 0);
    push("x0_wb", P_WB, 32'h55);
    push("x0_cmt", P_CMT, 32'h0);
    push("x0_byp", P_RS2, 32'h0);
    drain();
    cyc(0, 0, 0, 0, 0, 0, 7, 0);
    push("ld_rd", P_RS1, 32'hDEADBEEF);
    push("x0_rd", P_RS2, 32'h0);
    push("x0_cnt", P_CNT, 32'h2);
    drain();

    cyc(0, 1, 9, 0, 32'h11, 0, 0, 0);
    drain();
`ifdef REGFILE_BYPASS_EN
    rdw_exp = 32'h22;
`else
    rdw_exp = 32'h11;
`endif
    cyc(0, 1, 9, 0, 32'h22, 0, 9, 9);
    push("rdw_rs1", P_RS1, rdw_exp);
    push("rdw_rs2", P_RS2, rdw_exp);
    drain();
    cyc(0, 0, 0, 0, 0, 0, 9, 9);
    push("rdw_nx1", P_RS1, 32'h22);
    push("rdw_nx2", P_RS2, 32'h22);
    push("rdw_cnt", P_CNT, 32'h4);
    drain();

    cyc(0, 0, 4, 0, 32'h99, 0, 4, 0);
    push("dis_cmt", P_CMT, 32'h0);
    push("dis_rd", P_RS1, 32'h0);
    drain();
    cyc(0, 0, 0, 0, 0, 0, 4, 0);
    push("dis_rd2", P_RS1, 32'h0);
    push("dis_cnt", P_CNT, 32'h4);
    drain();
    cyc(0, 1, 4, 0, 32'h44, 0, 0, 0);
    drain();
    cyc(1, 1, 4, 0, 32'h77, 0, 4, 0);
    push("ro_cmt", P_CMT, 32'h0);
    push("ro_old", P_RS1, 32'h44);
    push("ro_cnt", P_CNT, 32'h5);
    drain();
    cyc(0, 0, 0, 0, 0, 0, 4, 3);
    push("ro_r4", P_RS1, 32'h0);
    push("ro_r3", P_RS2, 32'h0);
    push("ro_cnt0", P_CNT, 32'h0);
    drain();

    for (int i = 1; i <= 18; i++) begin
      if (i <= 17) begin
        cyc(0, 1, 5'(i), 0, 32'(i) * 32'h01010101, 0, 0, 0);
        push("wrap_cmt", P_SCM, 32'h1);
      end else begin
        cyc(0, 0, 0, 0, 0, 0, 5, 17);
      end
      push("wrap_cnt", P_SCN, 32'((i - 1) % 16));
      drain();
    end
    push("big_cnt", P_CNT, 32'd17);
    push("wrap_r5", P_SR1, 32'h05050505);
    push("wrap_r17", P_RS2, 32'h11111111);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
